// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one up-counter as a programmable delay timer among nReq requesters.
// Define DELAY_TIMER_ARB_PERIODIC_EN to let a lone requester re-arm the timer straight from DONE.
module delay_timer_arbiter #(
  parameter int nBits = 27,
  parameter int nReq  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [nReq-1:0]       req,
  input  logic [nReq*nBits-1:0] load_val,
  output logic [nReq-1:0]       gnt,
  output logic [nReq-1:0]       done,
  output logic                  busy,
  output logic [nBits-1:0]      count
);

  localparam int PW = (nReq > 1) ? $clog2(nReq) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [nReq-1:0]  gnt_q, gnt_d;
  logic [nReq-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [nBits-1:0] count_q, count_d;
  logic [nBits-1:0] target_q, target_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;

  logic             found_s;
  logic [PW-1:0]    pick_s;
  logic [PW-1:0]    idx_s;
  logic [nBits-1:0] pick_val_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (v == PW'(nReq - 1)) begin
      return '0;
    end else begin
      return v + PW'(1);
    end
  endfunction

  function automatic logic [nReq-1:0] onehot(input logic [PW-1:0] v);
    logic [nReq-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  // Rotating priority search: first set request at or above the pointer, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_q;
    idx_s   = ptr_q;
    for (int i = 0; i < nReq; i++) begin
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
      idx_s = wrap_inc(idx_s);
    end
  end

  assign pick_val_s = load_val[int'(pick_s)*nBits +: nBits];

`ifdef DELAY_TIMER_ARB_PERIODIC_EN
  logic             others_s;
  logic [nBits-1:0] win_val_s;

  assign others_s  = |(req & ~onehot(win_q));
  assign win_val_s = load_val[int'(win_q)*nBits +: nBits];
`endif

  // Next-state and next-output logic; abort in RUN has priority over reaching the target.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    count_d  = count_q;
    target_d = target_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          win_d    = pick_s;
          gnt_d    = onehot(pick_s);
          target_d = pick_val_s;
          count_d  = '0;
          ptr_d    = wrap_inc(pick_s);
          if (pick_val_s == '0) begin
            state_d = DONE;
            done_d  = onehot(pick_s);
          end else begin
            state_d = RUN;
          end
        end else begin
          gnt_d = '0;
        end
      end
      RUN: begin
        if (!req[win_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (count_q == target_q - nBits'(1)) begin
          state_d = DONE;
          count_d = target_q;
          done_d  = gnt_q;
        end else begin
          count_d = count_q + nBits'(1);
        end
      end
      DONE: begin
`ifdef DELAY_TIMER_ARB_PERIODIC_EN
        if (req[win_q] && !others_s) begin
          target_d = win_val_s;
          count_d  = '0;
          if (win_val_s == '0) begin
            state_d = DONE;
            done_d  = gnt_q;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
`else
        state_d = IDLE;
        gnt_d   = '0;
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      target_q <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Self-checking bench for delay_timer_arbiter (nBits=8, nReq=4): directed scenarios plus
// random traffic against an elapsed-time reference model.
module tb_delay_timer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] load_val;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: owner plus grant time; everything else follows from elapsed cycles
  int         m_owner = -1;
  int         m_gt = 0;
  int         m_tgt = 0;
  int         m_ptr = 0;
  logic [3:0] exp_gnt = 4'b0000;
  logic [3:0] exp_done = 4'b0000;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_cnt = 8'd0;

  delay_timer_arbiter #(.nBits(8), .nReq(4)) dut (
    .clk(clk), .rst(rst), .req(req), .load_val(load_val),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got still running, expected finish");
    $fatal(1);
  end

  task automatic model_edge(input logic rs, input logic [3:0] r, input logic [31:0] lv);
    int e;
    int w;
    if (!rs) begin
      m_owner = -1;
      m_ptr   = 0;
      exp_cnt = 8'd0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        w = (m_ptr + k) % 4;
        if (r[w]) begin
          m_owner = w;
          m_gt    = cyc;
          m_tgt   = int'(lv[w*8 +: 8]);
          m_ptr   = (w + 1) % 4;
          break;
        end
      end
    end else begin
      e = cyc - m_gt;
      if (e - 1 == m_tgt) begin
`ifdef DELAY_TIMER_ARB_PERIODIC_EN
        if (r[m_owner] && ((r & ~(4'b0001 << m_owner)) == 4'b0000)) begin
          m_gt  = cyc;
          m_tgt = int'(lv[m_owner*8 +: 8]);
        end else begin
          m_owner = -1;
        end
`else
        m_owner = -1;
`endif
      end else if (!r[m_owner]) begin
        m_owner = -1;
      end
    end
    if (m_owner >= 0) begin
      e        = cyc - m_gt;
      exp_gnt  = 4'b0001 << m_owner;
      exp_done = (e == m_tgt) ? exp_gnt : 4'b0000;
      exp_busy = 1'b1;
      exp_cnt  = 8'(e);
    end else begin
      exp_gnt  = 4'b0000;
      exp_done = 4'b0000;
      exp_busy = 1'b0;
    end
  endtask

  task automatic tick();
    logic [3:0]  r;
    logic [31:0] lv;
    logic        rs;
    r  = req;
    lv = load_val;
    rs = rst;
    @(posedge clk);
    cyc++;
    model_edge(rs, r, lv);
    #1;
  endtask

  task automatic settle();
    req = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    load_val = $urandom;
    repeat (2) begin
      tick();
      vectors++;
      if ({gnt, done, busy, count} !== 17'd0) begin
        miscompares++;
        $display("FAIL reset_state: got gnt=%b done=%b busy=%b count=%0d, expected all zero", gnt, done, busy, count);
      end
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_first_grant: got gnt=%b, expected 0001", gnt);
    end
    settle();
  endtask

  task automatic test_single_delay();
    load_val = $urandom;
    load_val[2*8 +: 8] = 8'd5;
    req = 4'b0100;
    tick();
    vectors++;
    if ({gnt, done, count} !== {4'b0100, 4'b0000, 8'd0}) begin
      miscompares++;
      $display("FAIL single_grant: got gnt=%b done=%b count=%0d, expected 0100 0000 0", gnt, done, count);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if ({gnt, done, count} !== {4'b0100, 4'b0000, 8'(k)}) begin
        miscompares++;
        $display("FAIL single_run: got gnt=%b done=%b count=%0d, expected 0100 0000 %0d", gnt, done, count, k);
      end
    end
    tick();
    vectors++;
    if ({gnt, done, count} !== {4'b0100, 4'b0100, 8'd5}) begin
      miscompares++;
      $display("FAIL single_done: got gnt=%b done=%b count=%0d, expected 0100 0100 5", gnt, done, count);
    end
    tick();
    vectors++;
    if ({gnt, done} !== 8'b0000_0000) begin
      miscompares++;
      $display("FAIL single_release: got gnt=%b done=%b, expected 0000 0000", gnt, done);
    end
    settle();
  endtask

  task automatic test_round_robin();
    int         order[$];
    int         exp_order[5];
    logic [3:0] prev;
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b0;
    tick();
    rst = 1'b1;
    load_val = {8'd2, 8'd2, 8'd2, 8'd2};
    req = 4'b1111;
    prev = 4'b0000;
    for (int n = 0; n < 40 && order.size() < 5; n++) begin
      tick();
      vectors++;
      if ({gnt, done, busy, count} !== {exp_gnt, exp_done, exp_busy, exp_cnt}) begin
        miscompares++;
        $display("FAIL rr_model: cyc=%0d got gnt=%b done=%b busy=%b count=%0d, expected gnt=%b done=%b busy=%b count=%0d",
                 cyc, gnt, done, busy, count, exp_gnt, exp_done, exp_busy, exp_cnt);
      end
      if (gnt != 4'b0000 && prev == 4'b0000) begin
        for (int k = 0; k < 4; k++) if (gnt[k]) order.push_back(k);
      end
      prev = gnt;
    end
    vectors++;
    if (order.size() != 5) begin
      miscompares++;
      $display("FAIL rr_count: got %0d grants, expected 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (order[k] != exp_order[k]) begin
          miscompares++;
          $display("FAIL rr_order: grant %0d got requester %0d, expected %0d", k, order[k], exp_order[k]);
        end
      end
    end
    settle();
  endtask

  task automatic test_zero_abort();
    bit saw_done;
    load_val = $urandom;
    load_val[1*8 +: 8] = 8'd0;
    req = 4'b0010;
    tick();
    vectors++;
    if ({gnt, done, count} !== {4'b0010, 4'b0010, 8'd0}) begin
      miscompares++;
      $display("FAIL zero_done: got gnt=%b done=%b count=%0d, expected 0010 0010 0", gnt, done, count);
    end
    tick();
    vectors++;
    if ({gnt, done} !== 8'b0000_0000) begin
      miscompares++;
      $display("FAIL zero_release: got gnt=%b done=%b, expected 0000 0000", gnt, done);
    end
    settle();
    load_val[3*8 +: 8] = 8'd10;
    req = 4'b1000;
    repeat (5) tick();
    vectors++;
    if ({gnt, count} !== {4'b1000, 8'd4}) begin
      miscompares++;
      $display("FAIL abort_setup: got gnt=%b count=%0d, expected 1000 4", gnt, count);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({gnt, done, busy, count} !== {4'b0000, 4'b0000, 1'b0, 8'd4}) begin
      miscompares++;
      $display("FAIL abort_idle: got gnt=%b done=%b busy=%b count=%0d, expected 0000 0000 0 4", gnt, done, busy, count);
    end
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      if (done != 4'b0000) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done || count !== 8'd4) begin
      miscompares++;
      $display("FAIL abort_no_done: got done_seen=%0d count=%0d, expected 0 4", saw_done, count);
    end
  endtask

  task automatic test_reset_mid_run();
    load_val = $urandom;
    load_val[0 +: 8] = 8'd20;
    req = 4'b0001;
    repeat (4) tick();
    vectors++;
    if (count !== 8'd3) begin
      miscompares++;
      $display("FAIL midrst_setup: got count=%0d, expected 3", count);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({gnt, done, busy, count} !== 17'd0) begin
      miscompares++;
      $display("FAIL midrst_clear: got gnt=%b done=%b busy=%b count=%0d, expected all zero", gnt, done, busy, count);
    end
    rst = 1'b1;
    settle();
  endtask

  task automatic test_max_value();
    int n;
    load_val = $urandom;
    load_val[0 +: 8] = 8'd255;
    req = 4'b0001;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      n++;
      if (done != 4'b0000) break;
    end
    vectors++;
    if (n != 256 || done !== 4'b0001 || count !== 8'd255) begin
      miscompares++;
      $display("FAIL max_done: got %0d cycles done=%b count=%0d, expected 256 0001 255", n, done, count);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({gnt, count} !== {4'b0000, 8'd255}) begin
      miscompares++;
      $display("FAIL max_hold: got gnt=%b count=%0d, expected 0000 255", gnt, count);
    end
    settle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) load_val[k*8 +: 8] = 8'($urandom_range(0, 6));
      rst = ($urandom_range(0, 99) != 0);
      tick();
      vectors++;
      if ({gnt, done, busy, count} !== {exp_gnt, exp_done, exp_busy, exp_cnt}) begin
        miscompares++;
        $display("FAIL random_model: cyc=%0d got gnt=%b done=%b busy=%b count=%0d, expected gnt=%b done=%b busy=%b count=%0d",
                 cyc, gnt, done, busy, count, exp_gnt, exp_done, exp_busy, exp_cnt);
      end
    end
    rst = 1'b1;
    settle();
  endtask

`ifdef DELAY_TIMER_ARB_PERIODIC_EN
  task automatic test_periodic();
    int  dones[$];
    int  n;
    bit  held;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    load_val = $urandom;
    load_val[0 +: 8] = 8'd3;
    req = 4'b0001;
    tick();
    held = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (gnt !== 4'b0001) held = 1'b0;
      if (done == 4'b0001) dones.push_back(cyc);
      vectors++;
      if ({gnt, done, busy, count} !== {exp_gnt, exp_done, exp_busy, exp_cnt}) begin
        miscompares++;
        $display("FAIL periodic_model: cyc=%0d got gnt=%b done=%b count=%0d, expected gnt=%b done=%b count=%0d",
                 cyc, gnt, done, count, exp_gnt, exp_done, exp_cnt);
      end
    end
    vectors++;
    if (!held || dones.size() < 3) begin
      miscompares++;
      $display("FAIL periodic_hold: got held=%0d dones=%0d, expected 1 and >=3", held, dones.size());
    end
    for (int k = 1; k < dones.size(); k++) begin
      vectors++;
      if (dones[k] - dones[k-1] != 4) begin
        miscompares++;
        $display("FAIL periodic_period: got %0d cycles, expected 4", dones[k] - dones[k-1]);
      end
    end
    req = 4'b0101;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n++;
      if (done != 4'b0000) break;
    end
    tick();
    vectors++;
    if (gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL periodic_yield: got gnt=%b, expected 0000", gnt);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0100 || n > 5) begin
      miscompares++;
      $display("FAIL periodic_handover: got gnt=%b wait=%0d, expected 0100 within 5", gnt, n);
    end
    settle();
  endtask
`endif

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    load_val = 32'd0;
    test_reset();
    test_single_delay();
    test_round_robin();
    test_zero_abort();
    test_reset_mid_run();
    test_max_value();
    test_random();
`ifdef DELAY_TIMER_ARB_PERIODIC_EN
    test_periodic();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
